// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative linear-mode CORDIC divider.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic longint one_f(input int frac);
    return longint'(1) << frac;
  endfunction

  // Largest positive ZW-bit two's-complement value: 0 followed by ones.
  function automatic longint sat_max_f(input int zw);
    return (longint'(1) << (zw - 1)) - 1;
  endfunction

  // Most negative ZW-bit two's-complement value: 1 followed by zeros.
  function automatic longint sat_min_f(input int zw);
    return -(longint'(1) << (zw - 1));
  endfunction

endpackage

// File: rtl/cordic_divide_step.sv
// One combinational linear-mode CORDIC iteration with a run-time shift index.
module cordic_divide_step
  import cordic_pkg::*;
#(
  parameter int WW   = 34,
  parameter int ZW   = 17,
  parameter int FRAC = 15,
  parameter int CW   = 5
) (
  input  logic signed [WW-1:0] x_i,
  input  logic signed [WW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic [CW-1:0]        i_i,
  output logic signed [WW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  localparam logic signed [ZW-1:0] ONE = ZW'(one_f(FRAC));

  logic signed [WW-1:0] x_sh;
  logic signed [ZW-1:0] z_step;

  always_comb begin
    x_sh   = x_i >>> i_i;
    z_step = ONE >>> i_i;
    // Drive the residual toward zero; the quotient moves opposite to it.
    if (y_i[WW-1]) begin
      y_o = y_i + x_sh;
      z_o = z_i - z_step;
    end else begin
      y_o = y_i - x_sh;
      z_o = z_i + z_step;
    end
  end

endmodule

// File: rtl/cordic_divide_iter.sv
// Iterative CORDIC divider z = y/x with sign normalisation, div0/overflow saturation and valid/ready.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; a held valid keeps its data stable.
module cordic_divide_iter
  import cordic_pkg::*;
#(
  parameter int DW   = 32,
  parameter int ZW   = 17,
  parameter int FRAC = 15,
  parameter int ITER = 16
) (
  input  logic          rx_clk,
  input  logic          rx_rst_n,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [DW-1:0] rx_y,
  input  logic [DW-1:0] rx_x,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [ZW-1:0] tx_z,
  output logic          tx_div0,
  output logic          tx_ovf,
  output logic [1:0]    dbg_state_o
);

  localparam int WW = DW + 2;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [ZW-1:0] Z_MAX = ZW'(sat_max_f(ZW));
  localparam logic [ZW-1:0] Z_MIN = ZW'(sat_min_f(ZW));

  state_e state_q, state_d;
  logic signed [WW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [CW-1:0]        i_q, i_d;
  logic                 div0_q, div0_d, ovf_q, ovf_d, yneg_q, yneg_d;

  logic signed [WW-1:0] x_ext, y_ext, x_norm, y_norm, y_abs, step_y;
  logic signed [ZW-1:0] step_z;
  logic                 acc_div0, acc_ovf;

  // Two guard bits let -(-2^(DW-1)) and 2|x| be represented exactly.
  always_comb begin
    x_ext    = {{2{rx_x[DW-1]}}, rx_x};
    y_ext    = {{2{rx_y[DW-1]}}, rx_y};
    x_norm   = rx_x[DW-1] ? -x_ext : x_ext;
    y_norm   = rx_x[DW-1] ? -y_ext : y_ext;
    y_abs    = y_norm[WW-1] ? -y_norm : y_norm;
    acc_div0 = (x_norm == '0);
    acc_ovf  = !acc_div0 && (y_abs >= (x_norm <<< 1));
  end

  cordic_divide_step #(
    .WW  (WW),
    .ZW  (ZW),
    .FRAC(FRAC),
    .CW  (CW)
  ) u_step (
    .x_i(x_q),
    .y_i(y_q),
    .z_i(z_q),
    .i_i(i_q),
    .y_o(step_y),
    .z_o(step_z)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    yneg_d  = yneg_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          x_d     = x_norm;
          y_d     = y_norm;
          z_d     = '0;
          i_d     = '0;
          div0_d  = acc_div0;
          ovf_d   = acc_ovf;
          yneg_d  = y_norm[WW-1];
          state_d = RUN;
        end
      end
      RUN: begin
        // Iterations run even for flagged operands so latency never varies.
        y_d = step_y;
        z_d = step_z;
        i_d = i_q + CW'(1);
        if (i_q == CW'(ITER - 1)) state_d = DONE;
      end
      DONE: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      yneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      yneg_q  <= yneg_d;
    end
  end

  assign rx_ready    = (state_q == IDLE);
  assign tx_valid    = (state_q == DONE);
  assign tx_z        = (div0_q || ovf_q) ? (yneg_q ? Z_MIN : Z_MAX) : z_q;
  assign tx_div0     = div0_q;
  assign tx_ovf      = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cordic_divide_iter.sv
// Self-checking bench for cordic_divide_iter: directed cases plus randomized operands against a reference model.
module tb_cordic_divide_iter;

  localparam int DW   = 32;
  localparam int ZW   = 17;
  localparam int FRAC = 15;
  localparam int ITER = 16;
  localparam longint ONE = longint'(1) << FRAC;
  localparam logic [ZW-1:0] ZMAX = 17'h0FFFF;
  localparam logic [ZW-1:0] ZMIN = 17'h10000;

  logic          rx_clk, rx_rst_n, rx_valid, rx_ready;
  logic [DW-1:0] rx_y, rx_x;
  logic          tx_valid, tx_ready, tx_div0, tx_ovf;
  logic [ZW-1:0] tx_z;
  logic [1:0]    dbg_state;

  typedef struct {
    logic [ZW-1:0] z;
    logic          div0;
    logic          ovf;
    longint        y;
    longint        x;
    int            acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic [ZW-1:0] last_z;
  logic last_div0, last_ovf;

  cordic_divide_iter #(.DW(DW), .ZW(ZW), .FRAC(FRAC), .ITER(ITER)) dut (
    .rx_clk     (rx_clk),
    .rx_rst_n   (rx_rst_n),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_y       (rx_y),
    .rx_x       (rx_x),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_z       (tx_z),
    .tx_div0    (tx_div0),
    .tx_ovf     (tx_ovf),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  always @(posedge rx_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input longint y, input longint x);
    exp_t   e;
    longint yn, xn, ya, z;
    logic   yneg;
    yn = (x < 0) ? -y : y;
    xn = (x < 0) ? -x : x;
    ya = (yn < 0) ? -yn : yn;
    yneg = (yn < 0);
    e.div0 = (xn == 0);
    e.ovf  = !e.div0 && (ya >= 2 * xn);
    z = 0;
    for (int i = 0; i < ITER; i++) begin
      if (yn < 0) begin
        yn = yn + (xn >>> i);
        z  = z - (ONE >>> i);
      end else begin
        yn = yn - (xn >>> i);
        z  = z + (ONE >>> i);
      end
    end
    if (e.div0 || e.ovf) e.z = yneg ? ZMIN : ZMAX;
    else                 e.z = ZW'(z);
    e.y = y;
    e.x = x;
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic int sz(input logic [ZW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint req, input longint tol);
    longint d;
    d = act - req;
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got %0d required %0d +/- %0d", name, act, req, tol);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge rx_clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 2) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input longint y, input longint x, input bit keep);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_y = DW'(y);
    rx_x = DW'(x);
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge rx_clk);
      if (rx_ready && rx_rst_n) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: rx_ready=0 for 200 cycles, required 1");
    end
    @(posedge rx_clk);
    #1;
    if (!keep) rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge rx_clk);
      if (exp_q.size() == 0 && !tx_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: %0d results pending after 300 cycles, required 0", exp_q.size());
    end
    @(posedge rx_clk);
    #1;
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin
    exp_t e;
    bit   expect_ready;
    bit   seen_valid;
    real  q, d;
    expect_ready = 1'b0;
    seen_valid   = 1'b0;
    forever begin
      @(negedge rx_clk);
      if (!rx_rst_n) begin
        expect_ready = 1'b0;
        seen_valid   = 1'b0;
      end else begin
        if (expect_ready) begin
          check("reaccept_ready", rx_ready, 1);
          expect_ready = 1'b0;
        end
        if (exp_q.size() > 0) check("busy_ready", rx_ready, 0);
        if (tx_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: tx_valid=1, required 0 (no operation pending)");
          end else begin
            e = exp_q[0];
            if (!seen_valid) begin
              check("latency", cyc - e.acc_cyc, ITER + 1);
              seen_valid = 1'b1;
            end
            check("tx_z", tx_z, e.z);
            check("tx_div0", tx_div0, e.div0);
            check("tx_ovf", tx_ovf, e.ovf);
            if (tx_ready) begin
              if (!e.div0 && !e.ovf && (e.x >= (1 << 20) || e.x <= -(1 << 20))) begin
                q = real'(e.y) * real'(ONE) / real'(e.x);
                d = real'(sz(tx_z)) - q;
                checks++;
                if (d > 2.0 || d < -2.0) begin
                  errors++;
                  $display("FAIL accuracy: got %0d required %f +/- 2 (y=%0d x=%0d)", sz(tx_z), q, e.y, e.x);
                end
              end
              last_z    = tx_z;
              last_div0 = tx_div0;
              last_ovf  = tx_ovf;
              void'(exp_q.pop_front());
              seen_valid   = 1'b0;
              expect_ready = 1'b1;
            end
          end
        end
        if (rx_valid && rx_ready) begin
          e = model(longint'($signed(rx_y)), longint'($signed(rx_x)));
          e.acc_cyc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    exp_t m;
    rx_rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_y = '0;
    rx_x = '0;

    // Hand-computed values pin the model.
    m = model(12288, 16384);
    check_tol("model_0p75", sz(m.z), 24576, 2);
    check("model_0p75_flags", {m.div0, m.ovf}, 0);
    m = model(12288, -16384);
    check_tol("model_m0p75", sz(m.z), -24576, 2);
    m = model(5, 0);
    check("model_div0_pos", m.z, 17'h0FFFF);
    m = model(-5, 0);
    check("model_div0_neg", m.z, 17'h10000);
    m = model(40000, 10000);
    check("model_ovf", {m.ovf, m.z}, {1'b1, 17'h0FFFF});

    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_z", tx_z, 0);
    check("rst_tx_div0", tx_div0, 0);
    check("rst_tx_ovf", tx_ovf, 0);
    check("rst_state", dbg_state, 0);
    rx_rst_n = 1'b1;
    @(posedge rx_clk);
    #1;

    // Directed cases.
    send(12288, 16384, 0);
    wait_idle();
    check_tol("dir_0p75", sz(last_z), 24576, 2);
    check("dir_0p75_flags", {last_div0, last_ovf}, 0);

    send(12288, -16384, 0);
    wait_idle();
    check_tol("dir_m0p75", sz(last_z), -24576, 2);

    send(-(longint'(1) << 31), -(longint'(1) << 31), 0);
    wait_idle();
    check_tol("dir_min_min", sz(last_z), 32768, 2);
    check("dir_min_min_ovf", last_ovf, 0);

    send(5, 0, 0);
    wait_idle();
    check("dir_div0_pos", {last_div0, last_z}, {1'b1, 17'h0FFFF});

    send(-5, 0, 0);
    wait_idle();
    check("dir_div0_neg", {last_div0, last_z}, {1'b1, 17'h10000});

    send(40000, 10000, 0);
    wait_idle();
    check("dir_ovf", {last_ovf, last_z}, {1'b1, 17'h0FFFF});

    send(19999, 10000, 0);
    wait_idle();
    check("dir_near2_ovf", last_ovf, 0);
    check_tol("dir_near2_z", sz(last_z), 65532, 8);

    // Back-to-back with a 5-cycle result stall.
    rdy_mode = 2;
    fork
      begin
        send(12288, 16384, 1);
        send(-5000000, 3000000, 0);
      end
      begin : stall_b
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
          @(negedge rx_clk);
          if (tx_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL stall_wait: tx_valid=0 for 100 cycles, required 1");
        end
        repeat (5) begin
          @(negedge rx_clk);
          check("stall_valid", tx_valid, 1);
        end
        @(posedge rx_clk);
        rdy_mode = 0;
      end
    join
    wait_idle();
    check_tol("dir_b2b_second", sz(last_z), -54613, 2);

    // Asynchronous reset in the middle of the iterations.
    send(12288, 16384, 0);
    repeat (7) @(posedge rx_clk);
    #1;
    rx_rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_rx_ready", rx_ready, 1);
    check("midrst_tx_z", tx_z, 0);
    check("midrst_flags", {tx_div0, tx_ovf}, 0);
    exp_q.delete();
    @(posedge rx_clk);
    #1;
    rx_rst_n = 1'b1;
    @(posedge rx_clk);
    #1;
    send(12288, 16384, 0);
    wait_idle();
    check_tol("post_rst_0p75", sz(last_z), 24576, 2);

    // Randomized operands with random downstream back-pressure.
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      longint ry, rx, ax;
      case ($urandom_range(0, 3))
        0: begin
          ry = longint'($signed($urandom()));
          rx = longint'($signed($urandom()));
        end
        1: begin
          ax = longint'($urandom_range(1 << 20, 1 << 30));
          rx = $urandom_range(0, 1) ? -ax : ax;
          ry = longint'($urandom_range(0, 32'(2 * ax - 1)));
          if ($urandom_range(0, 1)) ry = -ry;
        end
        2: begin
          rx = 0;
          ry = longint'($signed($urandom()));
        end
        default: begin
          ax = longint'($urandom_range(1, 1 << 29));
          rx = $urandom_range(0, 1) ? -ax : ax;
          ry = 2 * ax - longint'($urandom_range(0, 1));
          if ($urandom_range(0, 1)) ry = -ry;
        end
      endcase
      send(ry, rx, 1'($urandom_range(0, 1)));
    end
    rx_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
